edge_ctrl: RTL and testbench

Frame sequencer and configuration controller for the 3x3 edge-detect datapath. It sits on the video and control streams ahead of the datapath and tracks each pixel's column and row. It marks frame and line boundaries and flags pixels whose 3x3 window lies fully inside the frame. After every frame it drains the datapath pipeline, then applies threshold, geometry and mode settings received as control words.

---
 rtl/edge_pkg.sv | 38 +++
 rtl/edge_cfg_regs.sv | 78 +++++++
 rtl/edge_ctrl.sv | 154 +++++++++++++++
 tb/tb_edge_ctrl.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/edge_pkg.sv
// Shared constants and types for the edge-detect frame sequencer.
// Latency: none (declarations only).
// Backpressure: not applicable.
package edge_pkg;

  // Control word layout: [35:32] opcode, [31:0] payload
  localparam int CTRL_W = 36;
  localparam int OP_HI  = 35;
  localparam int OP_LO  = 32;
  localparam int PL_HI  = 31;
  localparam int PL_LO  = 0;
  localparam int DIM_W  = 12;

  localparam logic [3:0] OP_WIDTH  = 4'h1;
  localparam logic [3:0] OP_HEIGHT = 4'h2;
  localparam logic [3:0] OP_THRESH = 4'h3;
  localparam logic [3:0] OP_MODE   = 4'h4;
  localparam logic [3:0] OP_CLRERR = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DRAIN  = 2'd2
  } state_e;

  typedef struct packed {
    logic [DIM_W-1:0] width;
    logic [DIM_W-1:0] height;
    logic [DIM_W-1:0] thresh;
    logic             enable;
  } cfg_t;

  // A frame dimension must leave room for a full 3x3 window and fit the line buffers
  function automatic logic dim_ok(input logic [DIM_W-1:0] v, input int max_v);
    return (v >= 12'd3) && (int'(v) <= max_v);
  endfunction

endpackage

// File: rtl/edge_cfg_regs.sv
// Shadow/active configuration bank with dimension checking and sticky error flag.
// Latency: a write lands in shadow next cycle; active follows on the cycle apply_i is high.
// Backpressure: none, every control word is accepted.
module edge_cfg_regs
  import edge_pkg::*;
#(
  parameter int MAX_W      = 1920,
  parameter int MAX_H      = 1080,
  parameter int DEF_W      = 1920,
  parameter int DEF_H      = 1080,
  parameter int DEF_THRESH = 50
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_vld_i,
  input  logic [3:0]  wr_op_i,
  input  logic [31:0] wr_pl_i,
  input  logic        apply_i,
  output cfg_t        cfg_o,
  output logic        cfg_err_o
);

  localparam cfg_t CFG_RST = '{width:  DIM_W'(DEF_W),
                               height: DIM_W'(DEF_H),
                               thresh: DIM_W'(DEF_THRESH),
                               enable: 1'b1};

  cfg_t shadow_q, shadow_d;
  cfg_t active_q;
  logic err_q, err_d;
  logic unused_pl;

  // Upper payload bits carry no configuration
  assign unused_pl = ^wr_pl_i[31:12];

  // Decode a control word into the shadow bank; illegal dimensions only raise the error flag
  always_comb begin
    shadow_d = shadow_q;
    err_d    = err_q;
    if (wr_vld_i) begin
      case (wr_op_i)
        OP_WIDTH: begin
          if (dim_ok(wr_pl_i[11:0], MAX_W)) shadow_d.width = wr_pl_i[11:0];
          else                              err_d = 1'b1;
        end
        OP_HEIGHT: begin
          if (dim_ok(wr_pl_i[11:0], MAX_H)) shadow_d.height = wr_pl_i[11:0];
          else                              err_d = 1'b1;
        end
        OP_THRESH: shadow_d.thresh = wr_pl_i[11:0];
        OP_MODE:   shadow_d.enable = wr_pl_i[0];
        OP_CLRERR: err_d = 1'b0;
        default:   ;
      endcase
    end
  end

  // Shadow bank and sticky error track every accepted word
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q <= CFG_RST;
      err_q    <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      err_q    <= err_d;
    end
  end

  // Active bank copies the post-write shadow so a write on the apply cycle itself is included
  always_ff @(posedge clk) begin
    if (rst)          active_q <= CFG_RST;
    else if (apply_i) active_q <= shadow_d;
  end

  assign cfg_o     = active_q;
  assign cfg_err_o = err_q;

endmodule

// File: rtl/edge_ctrl.sv
// Frame sequencer: pixel col/row tracking, boundary/window flags, post-frame drain, config apply.
// Latency: flags are combinational on the beat; counters and state update on the next edge.
// Backpressure: ready mirrors downstream ready except during drain, where upstream is stalled.
module edge_ctrl
  import edge_pkg::*;
#(
  parameter int MAX_W      = 1920,
  parameter int MAX_H      = 1080,
  parameter int DEF_W      = 1920,
  parameter int DEF_H      = 1080,
  parameter int DEF_THRESH = 50,
  parameter int PIPE_LAT   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CTRL_W-1:0] control_in_data,
  input  logic              control_in_valid,
  input  logic              video_in_valid,
  input  logic              video_out_ready,
  output logic              video_in_ready,
  output logic [DIM_W-1:0]  pix_col,
  output logic [DIM_W-1:0]  pix_row,
  output logic              sof,
  output logic              eol,
  output logic              eof,
  output logic              win_valid,
  output logic              flush,
  output logic [DIM_W-1:0]  threshold,
  output logic              bypass,
  output logic              busy,
  output logic              cfg_err
);

  localparam int         DW       = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
  localparam logic [DW-1:0] DRN_INIT = DW'(PIPE_LAT - 1);

  state_e           state_q, state_d;
  logic [DIM_W-1:0] col_q, col_d, row_q, row_d;
  logic [DW-1:0]    drn_q, drn_d;
  cfg_t             cfg;
  logic             beat, tracking, trk_beat;
  logic             at_eol, at_last_row;
  logic             drain_last, apply;

  edge_cfg_regs #(
    .MAX_W      (MAX_W),
    .MAX_H      (MAX_H),
    .DEF_W      (DEF_W),
    .DEF_H      (DEF_H),
    .DEF_THRESH (DEF_THRESH)
  ) u_cfg (
    .clk       (clk),
    .rst       (rst),
    .wr_vld_i  (control_in_valid),
    .wr_op_i   (control_in_data[OP_HI:OP_LO]),
    .wr_pl_i   (control_in_data[PL_HI:PL_LO]),
    .apply_i   (apply),
    .cfg_o     (cfg),
    .cfg_err_o (cfg_err)
  );

  assign beat        = video_in_valid & video_in_ready;
  assign trk_beat    = beat & tracking;
  assign at_eol      = (col_q == cfg.width - 12'd1);
  assign at_last_row = (row_q == cfg.height - 12'd1);

  assign sof       = trk_beat & (col_q == '0) & (row_q == '0);
  assign eol       = trk_beat & at_eol;
  assign eof       = eol & at_last_row;
  assign win_valid = trk_beat & (col_q >= 12'd2) & (row_q >= 12'd2);

  // Config may change only between frames: in IDLE unless a frame is starting, or at drain exit
  assign apply = ((state_q == ST_IDLE) & ~trk_beat) | drain_last;

  assign pix_col   = col_q;
  assign pix_row   = row_q;
  assign threshold = cfg.thresh;
  assign bypass    = ~cfg.enable;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next state: a tracked beat opens a frame, the eof beat starts the drain, drain runs out to IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (trk_beat)   state_d = ST_ACTIVE;
      ST_ACTIVE: if (eof)        state_d = ST_DRAIN;
      ST_DRAIN:  if (drain_last) state_d = ST_IDLE;
      default:                   state_d = ST_IDLE;
    endcase
  end

  // State-decoded outputs; drain stalls upstream while the datapath is clocked empty
  always_comb begin
    video_in_ready = video_out_ready;
    flush          = 1'b0;
    busy           = 1'b0;
    tracking       = 1'b0;
    drain_last     = 1'b0;
    case (state_q)
      ST_IDLE:   tracking = cfg.enable;
      ST_ACTIVE: begin
        busy     = 1'b1;
        tracking = 1'b1;
      end
      ST_DRAIN: begin
        busy           = 1'b1;
        flush          = 1'b1;
        video_in_ready = 1'b0;
        drain_last     = (drn_q == '0);
      end
      default: ;
    endcase
  end

  // Position counters advance on tracked beats only; the eof beat wraps both to zero
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (trk_beat) begin
      if (at_eol) begin
        col_d = '0;
        row_d = at_last_row ? '0 : row_q + 12'd1;
      end else begin
        col_d = col_q + 12'd1;
      end
    end
  end

  // Drain length counter, loaded on the eof beat and counted down regardless of downstream ready
  always_comb begin
    drn_d = drn_q;
    if (eof)                                       drn_d = DRN_INIT;
    else if ((state_q == ST_DRAIN) && (drn_q != '0)) drn_d = drn_q - 1'b1;
  end

  // Counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      col_q <= '0;
      row_q <= '0;
      drn_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
      drn_q <= drn_d;
    end
  end

endmodule

// File: tb/tb_edge_ctrl.sv
// Scoreboard bench for edge_ctrl: stimulus queues expected per-beat position/flags, monitor checks.
// Latency: expectations are for the same cycle as the beat.
// Backpressure: exercised via video_out_ready stalls and the post-frame drain.
module tb_edge_ctrl;

  typedef struct packed {
    logic [11:0] col;
    logic [11:0] row;
    logic        sof;
    logic        eol;
    logic        eof;
    logic        win;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [35:0] control_in_data;
  logic        control_in_valid;
  logic        video_in_valid;
  logic        video_out_ready;
  logic        video_in_ready;
  logic [11:0] pix_col;
  logic [11:0] pix_row;
  logic        sof, eol, eof, win_valid, flush;
  logic [11:0] threshold;
  logic        bypass, busy, cfg_err;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  edge_ctrl dut (
    .clk              (clk),
    .rst              (rst),
    .control_in_data  (control_in_data),
    .control_in_valid (control_in_valid),
    .video_in_valid   (video_in_valid),
    .video_out_ready  (video_out_ready),
    .video_in_ready   (video_in_ready),
    .pix_col          (pix_col),
    .pix_row          (pix_row),
    .sof              (sof),
    .eol              (eol),
    .eof              (eof),
    .win_valid        (win_valid),
    .flush            (flush),
    .threshold        (threshold),
    .bypass           (bypass),
    .busy             (busy),
    .cfg_err          (cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // Start a new cycle: strobes drop, caller re-asserts what it needs
  task automatic tick();
    @(posedge clk);
    #1;
    control_in_valid = 1'b0;
    video_in_valid   = 1'b0;
  endtask

  task automatic wr(input logic [3:0] op, input logic [31:0] pl);
    control_in_valid = 1'b1;
    control_in_data  = {op, pl};
  endtask

  // Beat i of a 4x3 frame with hand-derived flag masks
  task automatic beat_frame(input int i);
    exp_t e;
    logic [11:0] sof_m, eol_m, eof_m, win_m;
    sof_m = 12'h001;
    eol_m = 12'h888;
    eof_m = 12'h800;
    win_m = 12'hC00;
    e.col = 12'(i % 4);
    e.row = 12'(i / 4);
    e.sof = sof_m[i];
    e.eol = eol_m[i];
    e.eof = eof_m[i];
    e.win = win_m[i];
    video_in_valid = 1'b1;
    exp_q.push_back(e);
  endtask

  task automatic frame_4x3();
    for (int i = 0; i < 12; i++) begin
      tick();
      beat_frame(i);
    end
  endtask

  // Four drain cycles then the first IDLE cycle, with the threshold expected in each phase
  task automatic drain(input logic [11:0] th_during, input logic [11:0] th_after);
    for (int k = 0; k < 4; k++) begin
      tick();
      video_in_valid = 1'b1;
      @(negedge clk);
      chk("drain_flush", flush, 1);
      chk("drain_ready", video_in_ready, 0);
      chk("drain_thresh", threshold, th_during);
    end
    tick();
    @(negedge clk);
    chk("post_flush", flush, 0);
    chk("post_busy", busy, 0);
    chk("post_ready", video_in_ready, 1);
    chk("post_thresh", threshold, th_after);
  endtask

  // Monitor: every beat consumes one expectation; non-beat cycles must show no flags
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (video_in_valid && video_in_ready) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_beat: got col %0d row %0d expected no beat", pix_col, pix_row);
        end else begin
          e = exp_q.pop_front();
          chk("beat", {4'h0, pix_col, pix_row, sof, eol, eof, win_valid}, {4'h0, e});
        end
      end else begin
        chk("no_flags", {28'h0, sof, eol, eof, win_valid}, 32'h0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    exp_t z;
    z = '0;
    rst = 1'b1;
    control_in_data = '0;
    control_in_valid = 1'b0;
    video_in_valid = 1'b0;
    video_out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_thresh", threshold, 50);
    chk("rst_col", pix_col, 0);
    chk("rst_row", pix_row, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cfg_err", cfg_err, 0);
    chk("rst_bypass", bypass, 0);
    chk("rst_flush", flush, 0);

    // Ready mirrors downstream in IDLE
    tick();
    video_out_ready = 1'b0;
    @(negedge clk);
    chk("mirror_lo", video_in_ready, 0);
    tick();
    video_out_ready = 1'b1;
    @(negedge clk);
    chk("mirror_hi", video_in_ready, 1);

    // Geometry 4x3
    tick();
    wr(4'h1, 32'd4);
    tick();
    wr(4'h2, 32'd3);
    tick();

    // Frame A: back-to-back
    frame_4x3();
    @(negedge clk);
    chk("frame_busy", busy, 1);
    drain(12'd50, 12'd50);

    // Frame B: threshold write mid-frame, stall at col 2 row 1
    for (int i = 0; i < 6; i++) begin
      tick();
      beat_frame(i);
      if (i == 3) wr(4'h3, 32'd80);
    end
    for (int k = 0; k < 5; k++) begin
      tick();
      video_out_ready = 1'b0;
      video_in_valid  = 1'b1;
      @(negedge clk);
      chk("stall_col", pix_col, 2);
      chk("stall_row", pix_row, 1);
      chk("stall_thresh", threshold, 50);
    end
    for (int i = 6; i < 12; i++) begin
      tick();
      video_out_ready = 1'b1;
      beat_frame(i);
    end
    drain(12'd50, 12'd80);

    // Rejected width keeps geometry; eof-cycle write applies at drain exit
    tick();
    wr(4'h1, 32'd2);
    tick();
    @(negedge clk);
    chk("err_set", cfg_err, 1);
    for (int i = 0; i < 12; i++) begin
      tick();
      beat_frame(i);
      if (i == 11) wr(4'h3, 32'd33);
    end
    drain(12'd80, 12'd33);
    tick();
    wr(4'hF, 32'd0);
    tick();
    @(negedge clk);
    chk("err_clr", cfg_err, 0);

    // Detection disabled: beats pass untracked
    tick();
    wr(4'h4, 32'd0);
    tick();
    @(negedge clk);
    chk("bypass_on", bypass, 1);
    for (int i = 0; i < 8; i++) begin
      tick();
      video_in_valid = 1'b1;
      exp_q.push_back(z);
    end
    tick();
    @(negedge clk);
    chk("bypass_busy", busy, 0);
    chk("bypass_col", pix_col, 0);
    tick();
    wr(4'h4, 32'd1);
    tick();
    @(negedge clk);
    chk("bypass_off", bypass, 0);

    // Reset during drain
    frame_4x3();
    tick();
    @(negedge clk);
    chk("pre_rst_flush", flush, 1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rstd_busy", busy, 0);
    chk("rstd_flush", flush, 0);
    chk("rstd_ready", video_in_ready, 1);
    chk("rstd_thresh", threshold, 50);
    chk("rstd_col", pix_col, 0);
    tick();
    video_out_ready = 1'b0;
    @(negedge clk);
    chk("rstd_ready_lo", video_in_ready, 0);
    tick();
    video_out_ready = 1'b1;

    for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(posedge clk);
    chk("queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
